// File: rtl/resize_frame_ctrl.sv
// resize_frame_ctrl: frame-level decimation controller for the video downscaler.
// Counts active pixels per frame and strobes the pixels that survive
// 1/2/4/8 decimation in both axes, with their output coordinates. Each
// completed output line is offered to the frame-buffer writer over a req/ack
// handshake. The frame is reported done once the final line is accepted.
//
// Ports:
//   iclk, irst_n            pixel clock, async active-low reset
//   iDVAL                   input pixel valid (one pixel per high cycle)
//   iFrame_start, iEnable   frame start pulse, frame processing enable
//   iScale[1:0]             log2 decimation factor, latched at frame start
//   iLine_ack, iClr_flags   writer line accept, sticky flag clear
//   oResize_valid           kept-pixel strobe, with oOut_x[9:0] / oOut_y[8:0]
//   oLine_req, oLine_idx    output line pending for the writer, and its row
//   oFrame_done             one-cycle frame completion pulse
//   oBusy                   controller not idle
//   oSync_err, oOverflow    sticky error flags
module resize_frame_ctrl #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480
) (
   input  logic       iclk,
   input  logic       irst_n,
   input  logic       iDVAL,
   input  logic       iFrame_start,
   input  logic       iEnable,
   input  logic [1:0] iScale,
   input  logic       iLine_ack,
   input  logic       iClr_flags,
   output logic       oResize_valid,
   output logic [9:0] oOut_x,
   output logic [8:0] oOut_y,
   output logic       oLine_req,
   output logic [8:0] oLine_idx,
   output logic       oFrame_done,
   output logic       oBusy,
   output logic       oSync_err,
   output logic       oOverflow
);

   localparam int unsigned XW = 10;
   localparam int unsigned YW = 9;
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t        state;
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;
   logic [1:0]    scale;

   logic [XW-1:0] x_mask;
   logic [YW-1:0] y_mask;
   logic          x_hit;
   logic          y_hit;
   logic          x_end;
   logic          y_end;

   // Decimation phase of the current pixel under the latched scale.
   always_comb begin
      x_mask = XW'((XW'(1) << scale) - XW'(1));
      y_mask = YW'((YW'(1) << scale) - YW'(1));
      x_hit  = (x_cnt & x_mask) == '0;
      y_hit  = (y_cnt & y_mask) == '0;
      x_end  = (x_cnt == X_LAST);
      y_end  = (y_cnt == Y_LAST);
   end

   // Frame FSM, pixel counters and all registered outputs.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state         <= IDLE;
         x_cnt         <= '0;
         y_cnt         <= '0;
         scale         <= '0;
         oResize_valid <= 1'b0;
         oOut_x        <= '0;
         oOut_y        <= '0;
         oLine_req     <= 1'b0;
         oLine_idx     <= '0;
         oFrame_done   <= 1'b0;
         oBusy         <= 1'b0;
         oSync_err     <= 1'b0;
         oOverflow     <= 1'b0;
      end else begin
         oResize_valid <= 1'b0;
         oFrame_done   <= 1'b0;
         if (iLine_ack) oLine_req <= 1'b0;
         // Clear first so a same-cycle set below takes precedence.
         if (iClr_flags) begin
            oSync_err <= 1'b0;
            oOverflow <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (iFrame_start && iEnable) begin
                  state <= ACTIVE;
                  oBusy <= 1'b1;
                  scale <= iScale;
                  x_cnt <= '0;
                  y_cnt <= '0;
               end
            end

            ACTIVE: begin
               if (iFrame_start) begin
                  // Restart the frame; a coincident pixel is not counted.
                  oSync_err <= 1'b1;
                  scale     <= iScale;
                  x_cnt     <= '0;
                  y_cnt     <= '0;
               end else if (iDVAL) begin
                  if (x_hit && y_hit) begin
                     oResize_valid <= 1'b1;
                     oOut_x        <= x_cnt >> scale;
                     oOut_y        <= y_cnt >> scale;
                  end
                  if (x_end) begin
                     x_cnt <= '0;
                     y_cnt <= y_cnt + YW'(1);
                     if (y_hit) begin
                        // New line wins over a same-cycle ack of the old one.
                        oLine_req <= 1'b1;
                        oLine_idx <= y_cnt >> scale;
                        if (oLine_req && !iLine_ack) oOverflow <= 1'b1;
                     end
                     if (y_end) state <= DRAIN;
                  end else begin
                     x_cnt <= x_cnt + XW'(1);
                  end
               end
            end

            DRAIN: begin
               if (iFrame_start) oSync_err <= 1'b1;
               // Finish as soon as no line is pending, including the ack cycle.
               if (!oLine_req || iLine_ack) begin
                  oFrame_done <= 1'b1;
                  oBusy       <= 1'b0;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
               oBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_resize_frame_ctrl.sv
// Self-checking bench for resize_frame_ctrl on a reduced 64x16 frame.
module tb_resize_frame_ctrl;

   localparam int H = 64;
   localparam int V = 16;
   localparam int ACK_DLY = 5;

   logic       iclk = 1'b0;
   logic       irst_n = 1'b0;
   logic       iDVAL = 1'b0;
   logic       iFrame_start = 1'b0;
   logic       iEnable = 1'b0;
   logic [1:0] iScale = 2'd0;
   logic       iLine_ack;
   logic       iClr_flags = 1'b0;
   logic       oResize_valid;
   logic [9:0] oOut_x;
   logic [8:0] oOut_y;
   logic       oLine_req;
   logic [8:0] oLine_idx;
   logic       oFrame_done;
   logic       oBusy;
   logic       oSync_err;
   logic       oOverflow;

   logic ack_force = 1'b0;
   logic ack_auto = 1'b0;
   logic ack_pulse = 1'b0;
   int   ack_wait = 0;

   int errors = 0;
   int checks = 0;

   logic [18:0] obs_kept[$];
   logic [8:0]  obs_lines[$];
   int          done_cnt = 0;
   logic        prev_req = 1'b0;

   assign iLine_ack = ack_force | ack_pulse;

   resize_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .iclk         (iclk),
      .irst_n       (irst_n),
      .iDVAL        (iDVAL),
      .iFrame_start (iFrame_start),
      .iEnable      (iEnable),
      .iScale       (iScale),
      .iLine_ack    (iLine_ack),
      .iClr_flags   (iClr_flags),
      .oResize_valid(oResize_valid),
      .oOut_x       (oOut_x),
      .oOut_y       (oOut_y),
      .oLine_req    (oLine_req),
      .oLine_idx    (oLine_idx),
      .oFrame_done  (oFrame_done),
      .oBusy        (oBusy),
      .oSync_err    (oSync_err),
      .oOverflow    (oOverflow)
   );

   always #5 iclk = ~iclk;

   // Output monitor, sampled shortly after each rising edge.
   always begin
      @(posedge iclk);
      #1;
      if (oResize_valid) obs_kept.push_back({oOut_y, oOut_x});
      if (oLine_req && !prev_req) obs_lines.push_back(oLine_idx);
      prev_req = oLine_req;
      if (oFrame_done) done_cnt++;
   end

   // Writer model: acks a pending line ACK_DLY cycles after it appears.
   initial begin
      forever begin
         @(negedge iclk);
         ack_pulse = 1'b0;
         if (ack_auto && oLine_req) begin
            if (ack_wait >= ACK_DLY) begin
               ack_pulse = 1'b1;
               ack_wait  = 0;
            end else begin
               ack_wait++;
            end
         end else begin
            ack_wait = 0;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset;
      irst_n = 1'b0;
      iDVAL = 1'b0;
      iFrame_start = 1'b0;
      iClr_flags = 1'b0;
      ack_force = 1'b0;
      ack_auto = 1'b0;
      repeat (3) @(negedge iclk);
      irst_n = 1'b1;
      @(negedge iclk);
   endtask

   task automatic start_frame(input int s);
      iScale = 2'(s);
      iEnable = 1'b1;
      iFrame_start = 1'b1;
      @(negedge iclk);
      iFrame_start = 1'b0;
   endtask

   // Drives n pixels with random idle gaps; iScale wanders to prove it is latched.
   task automatic drive_pixels(input int n, input int max_gap);
      int g;
      for (int i = 0; i < n; i++) begin
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (g) @(negedge iclk);
         iScale = 2'($urandom);
         iDVAL = 1'b1;
         @(negedge iclk);
         iDVAL = 1'b0;
      end
   endtask

   task automatic test_reset;
      logic [33:0] allv;
      do_reset;
      allv = {oResize_valid, oOut_x, oOut_y, oLine_req, oLine_idx,
              oFrame_done, oBusy, oSync_err, oOverflow};
      checks++;
      if (allv !== 34'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", allv);
      end
   endtask

   // Full frame at scale s against a reference list of kept pixels and lines.
   task automatic test_frame(input int s, input int max_gap);
      logic [18:0] ek[$];
      logic [8:0]  el[$];
      int f, k0, l0, d0, nk, nl;
      f = 1 << s;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            if ((y % f == 0) && (x % f == 0)) ek.push_back({9'(y / f), 10'(x / f)});
      for (int y = 0; y < V; y += f) el.push_back(9'(y / f));
      k0 = obs_kept.size();
      l0 = obs_lines.size();
      d0 = done_cnt;
      ack_auto = 1'b1;
      start_frame(s);
      drive_pixels(H * V, max_gap);
      for (int c = 0; c < 200 && done_cnt == d0; c++) @(negedge iclk);
      repeat (3) @(negedge iclk);
      nk = obs_kept.size() - k0;
      nl = obs_lines.size() - l0;
      checks++;
      if (nk !== ek.size()) begin
         errors++;
         $display("FAIL frame_s%0d_kept_count: got %0d expected %0d", s, nk, ek.size());
      end
      for (int i = 0; i < nk && i < ek.size(); i++) begin
         checks++;
         if (obs_kept[k0 + i] !== ek[i]) begin
            errors++;
            $display("FAIL frame_s%0d_kept[%0d]: got y=%0d x=%0d expected y=%0d x=%0d", s, i,
                     obs_kept[k0 + i][18:10], obs_kept[k0 + i][9:0], ek[i][18:10], ek[i][9:0]);
         end
      end
      checks++;
      if (nl !== el.size()) begin
         errors++;
         $display("FAIL frame_s%0d_line_count: got %0d expected %0d", s, nl, el.size());
      end
      for (int i = 0; i < nl && i < el.size(); i++) begin
         checks++;
         if (obs_lines[l0 + i] !== el[i]) begin
            errors++;
            $display("FAIL frame_s%0d_line[%0d]: got %0d expected %0d", s, i, obs_lines[l0 + i], el[i]);
         end
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL frame_s%0d_done_pulses: got %0d expected 1", s, done_cnt - d0);
      end
      checks++;
      if ({oBusy, oSync_err, oOverflow, oLine_req} !== 4'b0) begin
         errors++;
         $display("FAIL frame_s%0d_end_state: busy/sync/ovf/req got %b expected 0000", s,
                  {oBusy, oSync_err, oOverflow, oLine_req});
      end
      ack_auto = 1'b0;
   endtask

   task automatic test_back_to_back;
      test_frame(3, 0);
      test_frame(2, 1);
   endtask

   task automatic test_overflow;
      do_reset;
      start_frame(0);
      drive_pixels(H, 0);
      checks++;
      if ({oLine_req, oLine_idx, oOverflow} !== {1'b1, 9'd0, 1'b0}) begin
         errors++;
         $display("FAIL ovf_line0: req=%b idx=%0d ovf=%b expected 1 0 0", oLine_req, oLine_idx, oOverflow);
      end
      drive_pixels(H, 1);
      checks++;
      if ({oLine_req, oLine_idx, oOverflow} !== {1'b1, 9'd1, 1'b1}) begin
         errors++;
         $display("FAIL ovf_line1: req=%b idx=%0d ovf=%b expected 1 1 1", oLine_req, oLine_idx, oOverflow);
      end
      iClr_flags = 1'b1;
      @(negedge iclk);
      iClr_flags = 1'b0;
      checks++;
      if ({oOverflow, oLine_req} !== 2'b01) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b req=%b expected 0 1", oOverflow, oLine_req);
      end
      // Ack lands in the same cycle as the next line's last pixel.
      drive_pixels(H - 1, 0);
      iDVAL = 1'b1;
      ack_force = 1'b1;
      @(negedge iclk);
      iDVAL = 1'b0;
      ack_force = 1'b0;
      checks++;
      if ({oLine_req, oLine_idx, oOverflow} !== {1'b1, 9'd2, 1'b0}) begin
         errors++;
         $display("FAIL ovf_same_cycle_ack: req=%b idx=%0d ovf=%b expected 1 2 0", oLine_req, oLine_idx, oOverflow);
      end
      @(negedge iclk);
      checks++;
      if (oLine_req !== 1'b1) begin
         errors++;
         $display("FAIL ovf_req_held: got %b expected 1", oLine_req);
      end
   endtask

   task automatic test_sync_err;
      do_reset;
      ack_auto = 1'b1;
      start_frame(0);
      drive_pixels(1000, 0);
      // Restart at scale 1 with a coincident pixel that scale 0 would have kept.
      iScale = 2'd1;
      iFrame_start = 1'b1;
      iDVAL = 1'b1;
      @(negedge iclk);
      iFrame_start = 1'b0;
      iDVAL = 1'b0;
      checks++;
      if ({oResize_valid, oSync_err, oBusy} !== 3'b011) begin
         errors++;
         $display("FAIL sync_restart: valid/sync/busy got %b expected 011", {oResize_valid, oSync_err, oBusy});
      end
      drive_pixels(1, 0);
      checks++;
      if ({oResize_valid, oOut_x, oOut_y} !== {1'b1, 10'd0, 9'd0}) begin
         errors++;
         $display("FAIL sync_first_pixel: valid=%b x=%0d y=%0d expected 1 0 0", oResize_valid, oOut_x, oOut_y);
      end
      drive_pixels(1, 0);
      checks++;
      if (oResize_valid !== 1'b0) begin
         errors++;
         $display("FAIL sync_second_pixel_dropped: valid=%b expected 0", oResize_valid);
      end
      drive_pixels(1, 0);
      checks++;
      if ({oResize_valid, oOut_x, oOut_y} !== {1'b1, 10'd1, 9'd0}) begin
         errors++;
         $display("FAIL sync_third_pixel: valid=%b x=%0d y=%0d expected 1 1 0", oResize_valid, oOut_x, oOut_y);
      end
      iClr_flags = 1'b1;
      @(negedge iclk);
      iClr_flags = 1'b0;
      checks++;
      if (oSync_err !== 1'b0) begin
         errors++;
         $display("FAIL sync_clear: got %b expected 0", oSync_err);
      end
   endtask

   task automatic test_drain;
      int d0, k0;
      do_reset;
      ack_auto = 1'b1;
      start_frame(0);
      drive_pixels(H * (V - 1), 0);
      for (int c = 0; c < 20 && oLine_req; c++) @(negedge iclk);
      ack_auto = 1'b0;
      drive_pixels(H, 0);
      checks++;
      if ({oLine_req, oLine_idx} !== {1'b1, 9'(V - 1)}) begin
         errors++;
         $display("FAIL drain_final_req: req=%b idx=%0d expected 1 %0d", oLine_req, oLine_idx, V - 1);
      end
      d0 = done_cnt;
      k0 = obs_kept.size();
      iDVAL = 1'b1;
      repeat (10) @(negedge iclk);
      iDVAL = 1'b0;
      iFrame_start = 1'b1;
      @(negedge iclk);
      iFrame_start = 1'b0;
      checks++;
      if ({oBusy, oSync_err} !== 2'b11 || done_cnt !== d0 || obs_kept.size() !== k0) begin
         errors++;
         $display("FAIL drain_hold: busy/sync=%b done=%0d kept=%0d expected 11 0 0",
                  {oBusy, oSync_err}, done_cnt - d0, obs_kept.size() - k0);
      end
      ack_force = 1'b1;
      @(negedge iclk);
      ack_force = 1'b0;
      checks++;
      if ({oFrame_done, oLine_req, oBusy} !== 3'b100) begin
         errors++;
         $display("FAIL drain_done: done/req/busy got %b expected 100", {oFrame_done, oLine_req, oBusy});
      end
      @(negedge iclk);
      checks++;
      if (oFrame_done !== 1'b0) begin
         errors++;
         $display("FAIL drain_done_width: got %b expected 0", oFrame_done);
      end
   endtask

   task automatic test_reset_mid;
      int k0;
      logic [33:0] allv;
      do_reset;
      start_frame(0);
      drive_pixels(H + 6, 0);
      iDVAL = 1'b1;
      @(negedge iclk);
      irst_n = 1'b0;
      #2;
      allv = {oResize_valid, oOut_x, oOut_y, oLine_req, oLine_idx,
              oFrame_done, oBusy, oSync_err, oOverflow};
      checks++;
      if (allv !== 34'd0) begin
         errors++;
         $display("FAIL reset_mid_async: got %h expected 0", allv);
      end
      iDVAL = 1'b0;
      @(negedge iclk);
      irst_n = 1'b1;
      @(negedge iclk);
      k0 = obs_kept.size();
      iEnable = 1'b0;
      iFrame_start = 1'b1;
      @(negedge iclk);
      iFrame_start = 1'b0;
      drive_pixels(20, 0);
      checks++;
      if (oBusy !== 1'b0 || obs_kept.size() !== k0) begin
         errors++;
         $display("FAIL disabled_start: busy=%b kept=%0d expected 0 0", oBusy, obs_kept.size() - k0);
      end
   endtask

   initial begin
      test_reset;
      test_frame(1, 2);
      test_frame(0, 1);
      test_frame(3, 2);
      test_back_to_back;
      test_overflow;
      test_sync_err;
      test_drain;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/resize_frame_ctrl.md
# resize_frame_ctrl

Frame-level controller for the video downscaling path. Tracks the incoming active-pixel stream per frame, selects which pixels survive decimation by a per-frame scale factor (1, 2, 4 or 8 in both axes), and emits a registered keep strobe with output coordinates. Hands each completed output line to the downstream frame-buffer writer through a req/ack handshake and reports frame completion and sync/overflow errors. Sits between the TV decoder's pixel-valid stream and the line-buffer/SDRAM write logic.

## Interface
- H_ACTIVE, 640, active pixels per input line (power of two multiple of 8 not required; must be ≥ 8)
- V_ACTIVE, 480, active lines per input frame
- iclk  in  1  pixel clock
- irst_n  in  1  reset; one clock, reset is asynchronous and active-low
- iDVAL  in  1  input pixel valid, one pixel per high cycle
- iFrame_start  in  1  one-cycle pulse before first pixel of a frame
- iEnable  in  1  allow frames to be processed
- iScale  in  2  log2 decimation factor (0→1, 1→2, 2→4, 3→8), latched at frame start
- iLine_ack  in  1  writer accepted the pending line
- iClr_flags  in  1  clears sticky error flags
- oResize_valid  out  1  kept-pixel strobe
- oOut_x  out  10  output column of kept pixel
- oOut_y  out  9  output row of kept pixel
- oLine_req  out  1  output line complete, awaiting ack
- oLine_idx  out  9  output row of the pending line
- oFrame_done  out  1  one-cycle pulse at frame completion
- oBusy  out  1  state ≠ IDLE
- oSync_err  out  1  sticky: frame start during ACTIVE or DRAIN
- oOverflow  out  1  sticky: new line completed while previous unacknowledged

## Operation
- States: IDLE, ACTIVE, DRAIN. Reset → IDLE; all outputs 0, counters 0, latched scale 0.
- IDLE: iFrame_start & iEnable → latch s=iScale, clear x_cnt/y_cnt, go ACTIVE. iDVAL ignored.
- ACTIVE: each iDVAL increments x_cnt (10 b); at x_cnt=H_ACTIVE-1 wrap to 0, increment y_cnt (9 b).
- Keep rule: mask=(1<<s)-1; pixel kept iff (x_cnt & mask)=0 and (y_cnt & mask)=0. Then oOut_x=x_cnt>>s, oOut_y=y_cnt>>s.
- Kept line: input line with (y_cnt & mask)=0. Its last pixel (x_cnt=H_ACTIVE-1) sets oLine_req, oLine_idx=y_cnt>>s.
- oLine_req clears the cycle after iLine_ack sampled high. If a new line completes while oLine_req=1: with iLine_ack in that same cycle → req stays 1, idx updates, no error; without ack → oOverflow=1, idx updates to new line, req stays 1.
- Last pixel of line V_ACTIVE-1 → DRAIN. DRAIN: iDVAL ignored; when oLine_req=0 (incl. the cycle it clears), pulse oFrame_done, go IDLE.
- iFrame_start in ACTIVE: set oSync_err, re-latch iScale, clear counters, stay ACTIVE (restart frame; pending oLine_req preserved). In DRAIN: set oSync_err, ignored.
- iEnable deassert in ACTIVE/DRAIN: current frame completes normally; only gates IDLE→ACTIVE.
- iClr_flags clears both sticky flags; a same-cycle set wins.
- Reset mid-frame: immediate return to reset values, pending request dropped.

## Timing
- oResize_valid, oOut_x, oOut_y: registered, one cycle after the sampled iDVAL; valid high exactly one cycle per kept pixel.
- oLine_req rises one cycle after the last pixel of a kept line is sampled (same cycle as that pixel's oResize_valid would appear).
- iFrame_start coincident with iDVAL: start takes effect, that pixel is not counted; first counted pixel is the next iDVAL.
- oFrame_done: earliest one cycle after DRAIN entry; pulse exactly one cycle.
- Scale change on iScale mid-frame has no effect until next start.

## Test plan
- iScale=1, full 640×480 frame, ack 5 cycles after each req → 76800 oResize_valid pulses, 240 line reqs with idx 0..239, one oFrame_done, no flags.
- iScale=0 and iScale=3 frames → 307200 and 4800 kept pixels; last kept oOut_x=639/79, oOut_y=479/59.
- Hold iLine_ack low across two kept lines at iScale=0 → oOverflow=1, oLine_idx=1, req stays high; iClr_flags → flag 0.
- iFrame_start after 1000 pixels of a frame → oSync_err=1, next pixel yields oOut_x=0, oOut_y=0.
- Withhold ack on final line → DRAIN holds oBusy=1, no oFrame_done until one cycle after ack; iDVAL in DRAIN produces no oResize_valid.
- Assert irst_n low mid-line → all outputs 0 asynchronously; iFrame_start with iEnable=0 → stays IDLE.
